tp_transpose_unskew: RTL and testbench

//  Read-side receiver for the small-transpose bank memory of the TP-NTT datapath.
//  The transpose address generator issues per-bank read addresses rotated by (ctr mod S).

---
 rtl/tp_ntt_pkg.sv | 23 ++
 rtl/tp_lane_rotate.sv | 21 ++
 rtl/tp_transpose_unskew.sv | 110 +++++++++++
 tb/tb_tp_transpose_unskew.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tp_ntt_pkg.sv
// Shared TP-NTT helpers: block geometry derivation and MSB-first lane packing.
package tp_ntt_pkg;

  function automatic int unsigned calc_s(input int unsigned n1, input int unsigned n2,
                                         input int unsigned tp);
    return (n1 * n2) / tp;
  endfunction

  function automatic int unsigned calc_cw(input int unsigned s);
    return $clog2(s) + 1;
  endfunction

  function automatic int unsigned rot_width(input int unsigned tp);
    return (tp > 1) ? $clog2(tp) : 1;
  endfunction

  // Lane 0 occupies the most significant slice of a packed word.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned tp,
                                           input int unsigned logq);
    return (tp - 1 - lane) * logq;
  endfunction

endpackage

// File: rtl/tp_lane_rotate.sv
// Combinational lane rotator: dout lane i takes din lane (i+rot) mod TP.
module tp_lane_rotate
  import tp_ntt_pkg::*;
#(
  parameter int unsigned TP   = 8,
  parameter int unsigned LOGQ = 32
) (
  input  logic [LOGQ*TP-1:0]       din,
  input  logic [rot_width(TP)-1:0] rot,
  output logic [LOGQ*TP-1:0]       dout
);

  always_comb begin
    dout = '0;
    for (int unsigned i = 0; i < TP; i++) begin
      dout[lane_lsb(i, TP, LOGQ) +: LOGQ] =
        din[lane_lsb((i + 32'(rot)) % TP, TP, LOGQ) +: LOGQ];
    end
  end

endmodule

// File: rtl/tp_transpose_unskew.sv
// Transpose read-side receiver: tracks the generator's beat counter, delays the
// rotation to match address and memory latency, and un-rotates bank words.
module tp_transpose_unskew
  import tp_ntt_pkg::*;
#(
  parameter int unsigned n1     = 8,
  parameter int unsigned n2     = 2,
  parameter int unsigned TP     = 8,
  parameter int unsigned LOGQ   = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LOGQ*TP-1:0] rd_data,
  output logic [LOGQ*TP-1:0] out_data,
  output logic               out_valid,
  output logic               out_last,
  output logic               busy
);

  localparam int unsigned S     = calc_s(n1, n2, TP);
  localparam int unsigned CW    = calc_cw(S);
  localparam int unsigned RW    = rot_width(TP);
  localparam int unsigned DEPTH = RD_LAT + 2;
  localparam logic [CW-1:0] RMASK = CW'(S - 1);

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] r;
    logic          last;
  } beat_t;

  logic               st_q;
  logic [CW-1:0]      ctr;
  logic [CW-1:0]      r_full;
  beat_t              issue;
  beat_t              dl [DEPTH];
  logic               dl_any;
  logic [LOGQ*TP-1:0] rot_data;

  always_comb begin
    r_full      = ctr & RMASK;
    issue.valid = st_q;
    issue.r     = RW'(r_full);
    issue.last  = (r_full == RMASK);
  end

  // ctr is never cleared on idle so it stays in lock-step with the address generator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= 1'b0;
      ctr  <= '0;
    end else begin
      st_q <= start;
      if (st_q) begin
        ctr <= ctr + CW'(1);
      end
    end
  end

  // Stage 0 is the issue register; the remaining RD_LAT+1 stages cover the
  // generator's address register and the bank read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        dl[i] <= '0;
      end
    end else begin
      dl[0] <= issue;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        dl[i] <= dl[i-1];
      end
    end
  end

  always_comb begin
    dl_any = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      dl_any = dl_any | dl[i].valid;
    end
  end

  tp_lane_rotate #(
    .TP   (TP),
    .LOGQ (LOGQ)
  ) u_rotate (
    .din  (rd_data),
    .rot  (dl[DEPTH-1].r),
    .dout (rot_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (dl[DEPTH-1].valid) begin
      out_data  <= rot_data;
      out_valid <= 1'b1;
      out_last  <= dl[DEPTH-1].last;
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  assign busy = st_q | dl_any | out_valid;

endmodule

// File: tb/tb_tp_transpose_unskew.sv
// Bench for tp_transpose_unskew: bank model plus scoreboard of expected beats.
module tb_tp_transpose_unskew;

  localparam int unsigned TP      = 8;
  localparam int unsigned LOGQ    = 32;
  localparam int unsigned RD_LAT  = 1;
  localparam int unsigned N1      = 8;
  localparam int unsigned N2      = 2;
  localparam int unsigned S       = 2;
  localparam int unsigned CWB     = 2;
  localparam int unsigned MEM_DLY = RD_LAT + 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [LOGQ*TP-1:0] rd_data;
  logic [LOGQ*TP-1:0] out_data;
  logic               out_valid;
  logic               out_last;
  logic               busy;

  always #5 clk = ~clk;

  tp_transpose_unskew #(
    .n1     (N1),
    .n2     (N2),
    .TP     (TP),
    .LOGQ   (LOGQ),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rd_data   (rd_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .busy      (busy)
  );

  typedef struct {
    int unsigned seq;
    int unsigned r;
    logic        last;
  } exp_t;

  exp_t               sb[$];
  int                 checks = 0;
  int                 errors = 0;
  logic               m_st = 1'b0;
  int unsigned        m_ctr = 0;
  int unsigned        seq_n = 0;
  logic               mp_v   [MEM_DLY];
  int unsigned        mp_seq [MEM_DLY];
  int unsigned        obs_r[$];
  logic               obs_last[$];
  int                 obs_tick[$];
  logic [LOGQ*TP-1:0] obs_data[$];
  logic               busy_at [4096];
  int                 tick_n = 0;
  int                 burst_base = 0;

  // Lane i carries {seq, (i+r) mod TP}; with r=0 this is also the raw bank word.
  function automatic logic [LOGQ*TP-1:0] exp_word(input int unsigned seq, input int unsigned r);
    logic [LOGQ*TP-1:0] w;
    w = '0;
    for (int unsigned i = 0; i < TP; i++) begin
      w[(TP-1-i)*LOGQ +: LOGQ] = {16'(seq), 16'((i + r) % TP)};
    end
    return w;
  endfunction

  task automatic clear_model();
    m_st  = 1'b0;
    m_ctr = 0;
    for (int j = 0; j < MEM_DLY; j++) begin
      mp_v[j]   = 1'b0;
      mp_seq[j] = 0;
    end
    sb.delete();
  endtask

  task automatic tick();
    exp_t e;
    logic launch;
    @(negedge clk);
    tick_n++;
    busy_at[tick_n % 4096] = busy;
    if (out_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_beat tick=%0d got out_valid=1 required no beat", tick_n);
      end else begin
        e = sb.pop_front();
        checks++;
        if (out_data !== exp_word(e.seq, e.r)) begin
          errors++;
          $display("FAIL sb_data seq=%0d got %h required %h", e.seq, out_data, exp_word(e.seq, e.r));
        end
        checks++;
        if (out_last !== e.last) begin
          errors++;
          $display("FAIL sb_last seq=%0d got %b required %b", e.seq, out_last, e.last);
        end
      end
      obs_r.push_back(32'(out_data[(TP-1)*LOGQ +: 16]));
      obs_last.push_back(out_last);
      obs_tick.push_back(tick_n);
      obs_data.push_back(out_data);
    end else begin
      checks++;
      if (out_valid !== 1'b0 || out_last !== 1'b0) begin
        errors++;
        $display("FAIL idle_flags tick=%0d got valid=%b last=%b required 0 0", tick_n, out_valid, out_last);
      end
    end
    // Advance the generator/bank model by the posedge just passed.
    launch = m_st;
    for (int j = MEM_DLY - 1; j > 0; j--) begin
      mp_v[j]   = mp_v[j-1];
      mp_seq[j] = mp_seq[j-1];
    end
    mp_v[0]   = launch;
    mp_seq[0] = seq_n;
    if (launch) begin
      sb.push_back('{seq: seq_n, r: m_ctr % S, last: ((m_ctr % S) == S - 1)});
      seq_n++;
      m_ctr = (m_ctr + 1) % (1 << CWB);
    end
    m_st = start;
    rd_data = mp_v[MEM_DLY-1] ? exp_word(mp_seq[MEM_DLY-1], 0) : '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    rd_data = '0;
    clear_model();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got v=%b l=%b b=%b required 0 0 0", out_valid, out_last, busy);
    end
    checks++;
    if (out_data !== '0) begin
      errors++;
      $display("FAIL reset_data got %h required 0", out_data);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_burst();
    int ts;
    ts = tick_n;
    burst_base = obs_r.size();
    start = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (obs_r.size() != burst_base + 4) begin
      errors++;
      $display("FAIL burst_count got %0d required 4", obs_r.size() - burst_base);
    end else begin
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (obs_tick[burst_base+j] != ts + 5 + j) begin
          errors++;
          $display("FAIL burst_timing beat=%0d got tick %0d required %0d", j, obs_tick[burst_base+j], ts + 5 + j);
        end
        checks++;
        if (obs_last[burst_base+j] !== 1'(j % 2)) begin
          errors++;
          $display("FAIL burst_last beat=%0d got %b required %0d", j, obs_last[burst_base+j], j % 2);
        end
      end
    end
  endtask

  task automatic test_lane_order();
    logic [LOGQ*TP-1:0] d;
    logic [LOGQ-1:0]    lane;
    int unsigned        rr;
    checks++;
    if (obs_data.size() < burst_base + 3) begin
      errors++;
      $display("FAIL lane_order_avail got %0d beats required 3", obs_data.size() - burst_base);
    end else begin
      for (int b = 0; b < 3; b++) begin
        d  = obs_data[burst_base+b];
        rr = (b == 1) ? 1 : 0;
        for (int unsigned i = 0; i < TP; i++) begin
          lane = d[(TP-1-i)*LOGQ +: LOGQ];
          checks++;
          if (lane[15:0] !== 16'((i + rr) % TP)) begin
            errors++;
            $display("FAIL lane_order beat=%0d lane=%0d got bank %0d required %0d", b, i, lane[15:0], (i + rr) % TP);
          end
        end
      end
    end
  endtask

  task automatic test_single_beat();
    int base;
    for (int k = 0; k < 2; k++) begin
      base = obs_r.size();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      checks++;
      if (obs_r.size() != base + 1) begin
        errors++;
        $display("FAIL single_count run=%0d got %0d required 1", k, obs_r.size() - base);
      end else begin
        checks++;
        if (obs_r[base] != 32'(k) || obs_last[base] !== 1'(k)) begin
          errors++;
          $display("FAIL single_rot run=%0d got r=%0d last=%b required r=%0d last=%0d", k, obs_r[base], obs_last[base], k, k);
        end
      end
    end
  endtask

  task automatic test_bubble_drain();
    logic pat [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    int base, ts, tl;
    base = obs_r.size();
    ts = tick_n;
    for (int i = 0; i < 6; i++) begin
      start = pat[i];
      tick();
    end
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (obs_r.size() != base + 5) begin
      errors++;
      $display("FAIL bubble_count got %0d required 5", obs_r.size() - base);
    end else begin
      for (int j = 0; j < 5; j++) begin
        checks++;
        if (obs_r[base+j] != 32'(j % 2)) begin
          errors++;
          $display("FAIL bubble_rot beat=%0d got %0d required %0d", j, obs_r[base+j], j % 2);
        end
      end
      tl = obs_tick[base+4];
      checks++;
      if (tl - obs_tick[base] != 5) begin
        errors++;
        $display("FAIL bubble_span got %0d required 5", tl - obs_tick[base]);
      end
      for (int t = ts + 1; t <= tl; t++) begin
        checks++;
        if (busy_at[t % 4096] !== 1'b1) begin
          errors++;
          $display("FAIL busy_drain tick=%0d got %b required 1", t, busy_at[t % 4096]);
        end
      end
      checks++;
      if (busy_at[(tl + 1) % 4096] !== 1'b0) begin
        errors++;
        $display("FAIL busy_drop got %b required 0", busy_at[(tl + 1) % 4096]);
      end
    end
  endtask

  task automatic test_async_reset();
    int base;
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL inflight_busy got %b required 1", busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL async_reset got v=%b l=%b b=%b d=%h required all 0", out_valid, out_last, busy, out_data);
    end
    clear_model();
    #1;
    rst = 1'b0;
    base = obs_r.size();
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (obs_r.size() != base) begin
      errors++;
      $display("FAIL post_reset_quiet got %0d beats required 0", obs_r.size() - base);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (obs_r.size() != base + 1 || obs_r[base] != 0) begin
      errors++;
      $display("FAIL post_reset_rot got count=%0d required count=1 r=0", obs_r.size() - base);
    end
  endtask

  task automatic test_ctr_wrap();
    int base;
    rst = 1'b1;
    clear_model();
    #1;
    rst = 1'b0;
    base = obs_r.size();
    start = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (obs_r.size() != base + 9) begin
      errors++;
      $display("FAIL wrap_count got %0d required 9", obs_r.size() - base);
    end else begin
      for (int j = 0; j < 9; j++) begin
        checks++;
        if (obs_r[base+j] != 32'(j % 2) || obs_last[base+j] !== 1'(j % 2)) begin
          errors++;
          $display("FAIL wrap_rot beat=%0d got r=%0d last=%b required r=%0d", j, obs_r[base+j], obs_last[base+j], j % 2);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_lane_order();
    test_single_beat();
    test_bubble_drain();
    test_async_reset();
    test_ctr_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
